// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed 7-segment bus back to a debounced 4-digit BCD frame
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       timeout
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;
  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: return 4'd0;
      7'b0110000: return 4'd1;
      7'b1101101: return 4'd2;
      7'b1111001: return 4'd3;
      7'b0110011: return 4'd4;
      7'b1011011: return 4'd5;
      7'b1011111: return 4'd6;
      7'b1110000: return 4'd7;
      7'b1111111: return 4'd8;
      7'b1111011: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction
  logic [10:0]     sync1_q, sync2_q;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [10:0]     ref_q, ref_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0]      seen_q, seen_d;
  logic            err_acc_q, err_acc_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_q, timeout_d;
  logic [3:0]      s_an;
  logic [6:0]      s_seg;
  logic            one_hot, capture;
  logic [1:0]      idx;
  logic [3:0]      dec;
  assign s_an    = sync2_q[10:7];
  assign s_seg   = sync2_q[6:0];
  assign one_hot = (s_an != 4'd0) && ((s_an & (s_an - 4'd1)) == 4'd0);
  assign idx     = {s_an[3] | s_an[2], s_an[3] | s_an[1]};
  assign dec     = decode(s_seg);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    capture = 1'b0;
    if (state_q == WAIT || sync2_q != ref_q) begin
      state_d = one_hot ? COUNT : WAIT;
      cnt_d   = one_hot ? CW'(1) : CW'(0);
      ref_d   = one_hot ? sync2_q : ref_q;
    end else if (state_q == COUNT) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(STABLE_CYCLES)) begin
        capture = 1'b1;
        state_d = HELD;
      end
    end
  end
  always_comb begin
    shadow_d      = shadow_q;
    seen_d        = seen_q;
    err_acc_d     = err_acc_q;
    digits_d      = digits_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = 1'b0;
    timeout_d     = 1'b0;
    idle_d        = idle_q + IW'(1);
    if (capture) begin
      shadow_d[idx] = dec;
      seen_d[idx]   = 1'b1;
      err_acc_d     = err_acc_q | (dec == 4'hF);
      idle_d        = '0;
      if (&seen_d) begin
        digits_d      = shadow_d;
        frame_err_d   = err_acc_d;
        frame_valid_d = 1'b1;
        seen_d        = '0;
        err_acc_d     = 1'b0;
      end
    end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
      seen_d    = '0;
      err_acc_d = 1'b0;
      timeout_d = 1'b1;
      idle_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      state_q       <= WAIT;
      cnt_q         <= '0;
      ref_q         <= '0;
      shadow_q      <= '0;
      seen_q        <= '0;
      err_acc_q     <= 1'b0;
      idle_q        <= '0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      sync1_q       <= {an, seg};
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ref_q         <= ref_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      err_acc_q     <= err_acc_d;
      idle_q        <= idle_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      timeout_q     <= timeout_d;
    end
  end
  assign digit0      = digits_q[0];
  assign digit1      = digits_q[1];
  assign digit2      = digits_q[2];
  assign digit3      = digits_q[3];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and random scans checked against a run-length reference model
module tb_seg_scan_decoder;
  localparam int ST = 4;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] seg = '0;
  logic [3:0] an = '0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic frame_valid, frame_err, timeout;
  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int to_cnt = 0;
  logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [10:0] p1, p2, prev;
  int run, idle;
  logic [3:0] shadow [4];
  logic [3:0] ed [4];
  logic [3:0] seen;
  logic errac, efv, efe, eto;
  always #5 clk = ~clk;
  seg_scan_decoder #(.STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .frame_valid(frame_valid), .frame_err(frame_err), .timeout(timeout)
  );
  function automatic logic [3:0] dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (pat[i] == s) return 4'(i);
    return 4'hF;
  endfunction
  task automatic model_reset();
    p1 = '0; p2 = '0; prev = '0; run = 0; idle = 0;
    seen = '0; errac = 1'b0; efv = 1'b0; efe = 1'b0; eto = 1'b0;
    for (int i = 0; i < 4; i++) begin shadow[i] = '0; ed[i] = '0; end
  endtask
  // A digit is captured when the synced sample has been identical for exactly ST edges.
  task automatic model_edge();
    logic [10:0] smp;
    int k;
    smp = p2; p2 = p1; p1 = {an, seg};
    run = (smp == prev) ? ((run < ST + 1) ? run + 1 : run) : 1;
    prev = smp;
    efv = 1'b0; eto = 1'b0;
    if ($countones(smp[10:7]) == 1 && run == ST) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (smp[7 + i]) k = i;
      shadow[k] = dec(smp[6:0]);
      seen[k] = 1'b1;
      errac = errac | (shadow[k] == 4'hF);
      idle = 0;
      if (seen == 4'hF) begin
        for (int i = 0; i < 4; i++) ed[i] = shadow[i];
        efe = errac; efv = 1'b1; seen = '0; errac = 1'b0;
      end
    end else if (idle == TO - 1) begin
      seen = '0; errac = 1'b0; eto = 1'b1; idle = 0;
    end else idle++;
  endtask
  task automatic chk();
    fv_cnt += int'(frame_valid);
    to_cnt += int'(timeout);
    total += 3;
    assert (frame_valid === efv) else begin bad++; $error("FAIL frame_valid got=%0b exp=%0b t=%0t", frame_valid, efv, $time); end
    assert (timeout === eto) else begin bad++; $error("FAIL timeout got=%0b exp=%0b t=%0t", timeout, eto, $time); end
    assert ({digit3, digit2, digit1, digit0, frame_err} === {ed[3], ed[2], ed[1], ed[0], efe})
      else begin bad++; $error("FAIL digits_err got=%h exp=%h t=%0t", {digit3, digit2, digit1, digit0, frame_err}, {ed[3], ed[2], ed[1], ed[0], efe}, $time); end
  endtask
  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin bad++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end
  endtask
  task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      an = a; seg = s;
      @(posedge clk);
      model_edge();
      #1 chk();
    end
  endtask
  task automatic scan(input int d0, input int d1, input int d2, input logic [6:0] s3);
    step(4'b0001, pat[d0], 8);
    step(4'b0010, pat[d1], 8);
    step(4'b0100, pat[d2], 8);
    step(4'b1000, s3, 8);
    step(4'b0000, 7'h00, 4);
  endtask
  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int r;
    model_reset();
    repeat (2) @(posedge clk);
    #1 expect_eq("reset_outputs", {digit3, digit2, digit1, digit0, frame_valid, frame_err, timeout}, 0);
    rst_n = 1'b1;
    fv_cnt = 0;
    scan(1, 2, 3, pat[4]);
    expect_eq("t1_frames", fv_cnt, 1);
    expect_eq("t1_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    expect_eq("t1_err", frame_err, 0);
    fv_cnt = 0;
    step(4'b0001, pat[1], 8);
    step(4'b0010, pat[2], 8);
    for (int i = 0; i < 5; i++) step(4'b0100, (i % 2) ? pat[3] : pat[2], 2);
    step(4'b0100, pat[2], 8);
    step(4'b1000, pat[4], 8);
    step(4'b0000, 7'h00, 4);
    expect_eq("t2_frames", fv_cnt, 1);
    expect_eq("t2_digits", {digit3, digit2, digit1, digit0}, 16'h4221);
    scan(1, 2, 3, 7'b0000001);
    expect_eq("t3_bad_digits", {digit3, digit2, digit1, digit0}, 16'hF321);
    expect_eq("t3_bad_err", frame_err, 1);
    scan(5, 6, 7, pat[8]);
    expect_eq("t3_clean_digits", {digit3, digit2, digit1, digit0}, 16'h8765);
    expect_eq("t3_clean_err", frame_err, 0);
    fv_cnt = 0;
    step(4'b0000, pat[8], 10);
    step(4'b0110, pat[8], 20);
    expect_eq("t4_no_frame", fv_cnt, 0);
    scan(9, 0, 1, pat[2]);
    expect_eq("t4_digits", {digit3, digit2, digit1, digit0}, 16'h2109);
    step(4'b0001, pat[3], 8);
    step(4'b0010, pat[4], 8);
    fv_cnt = 0; to_cnt = 0;
    step(4'b0000, 7'h00, 60);
    expect_eq("t5_timeouts", to_cnt, 1);
    expect_eq("t5_no_frame", fv_cnt, 0);
    expect_eq("t5_digits_kept", {digit3, digit2, digit1, digit0}, 16'h2109);
    step(4'b0001, pat[9], 8);
    step(4'b0010, pat[8], 8);
    step(4'b0100, pat[7], 8);
    rst_n = 1'b0;
    #1 expect_eq("t6_async_reset", {digit3, digit2, digit1, digit0, frame_valid, frame_err, timeout}, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    fv_cnt = 0;
    scan(9, 8, 7, pat[6]);
    expect_eq("t6_frames", fv_cnt, 1);
    expect_eq("t6_digits", {digit3, digit2, digit1, digit0}, 16'h6789);
    repeat (150) begin
      r = $urandom_range(0, 9);
      a = (r < 7) ? 4'(1 << $urandom_range(0, 3)) : (r == 7) ? 4'b0000 : 4'($urandom);
      s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pat[$urandom_range(0, 9)];
      step(a, s, $urandom_range(1, 8));
    end
    step(4'b0000, 7'h00, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
